// File: rtl/bcd_upcounter_2d_if.sv
// Control/status bundle for bcd_upcounter_2d: clear and start/pause requests in,
// BCD digits, carry, done flag, FSM state and LED bank out.
interface bcd_upcounter_2d_if;
   logic        i_clr;
   logic        i_start_pause;
   logic [3:0]  o_d0;
   logic [3:0]  o_d1;
   logic        o_cy0;
   logic        o_done;
   logic [1:0]  o_state;
   logic [15:0] o_LEDs;

   modport master (
      output i_clr, i_start_pause,
      input  o_d0, o_d1, o_cy0, o_done, o_state, o_LEDs
   );

   modport slave (
      input  i_clr, i_start_pause,
      output o_d0, o_d1, o_cy0, o_done, o_state, o_LEDs
   );
endinterface

// File: rtl/bcd_upcounter_2d.sv
// Two-digit BCD up-counter (00 -> LIMIT) with start/pause, clear and a terminal DONE state.
// Optional macro UPCNT_LED_BLINK_EN makes the LED bank blink in DONE instead of staying lit.
module bcd_upcounter_2d #(
   parameter logic [3:0] LIMIT_D1 = 4'd3,
   parameter logic [3:0] LIMIT_D0 = 4'd0
) (
   input logic              clk_d,
   input logic              rst,
   bcd_upcounter_2d_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [7:0] LIMIT = {LIMIT_D1, LIMIT_D0};

   generate
      if (LIMIT_D1 > 4'd9 || LIMIT_D0 > 4'd9) begin : g_badLimit
         $error("bcd_upcounter_2d: LIMIT digits must be BCD (0-9)");
      end
   endgenerate

   logic [1:0] r_state;
   logic [3:0] r_d0;
   logic [3:0] r_d1;

   logic [1:0] w_nextState;
   logic [3:0] w_nextD0;
   logic [3:0] w_nextD1;
   logic [3:0] w_incD0;
   logic [3:0] w_incD1;
   logic       w_hitLimit;

   // Candidate BCD increment; the limit test looks at the incremented value so DONE lands on the same edge
   assign w_incD0    = (r_d0 == 4'd9) ? 4'd0 : r_d0 + 4'd1;
   assign w_incD1    = (r_d0 == 4'd9) ? r_d1 + 4'd1 : r_d1;
   assign w_hitLimit = ({w_incD1, w_incD0} == LIMIT);

   always_comb begin
      w_nextState = r_state;
      w_nextD0    = r_d0;
      w_nextD1    = r_d1;
      if (bus.i_clr) begin
         w_nextState = IDLE;
         w_nextD0    = 4'd0;
         w_nextD1    = 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_start_pause)
                  w_nextState = (LIMIT == 8'h00) ? DONE : RUN;
            end
            RUN: begin
               if (bus.i_start_pause) begin
                  w_nextState = PAUSE;
               end else begin
                  w_nextD0 = w_incD0;
                  w_nextD1 = w_incD1;
                  if (w_hitLimit)
                     w_nextState = DONE;
               end
            end
            PAUSE: begin
               if (bus.i_start_pause)
                  w_nextState = RUN;
            end
            DONE: begin
               w_nextState = DONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_d0    <= 4'd0;
         r_d1    <= 4'd0;
      end else begin
         r_state <= w_nextState;
         r_d0    <= w_nextD0;
         r_d1    <= w_nextD1;
      end
   end

   assign bus.o_d0    = r_d0;
   assign bus.o_d1    = r_d1;
   assign bus.o_state = r_state;
   assign bus.o_done  = (r_state == DONE);
   assign bus.o_cy0   = (r_state == RUN) && (r_d0 == 4'd9) && !bus.i_clr && !bus.i_start_pause;

`ifdef UPCNT_LED_BLINK_EN
   logic r_blink;

   // Blink phase is forced high on DONE entry so the first DONE cycle shows a lit bank
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst)
         r_blink <= 1'b0;
      else if (bus.i_clr)
         r_blink <= 1'b0;
      else if (w_nextState == DONE)
         r_blink <= (r_state == DONE) ? ~r_blink : 1'b1;
      else
         r_blink <= 1'b0;
   end

   assign bus.o_LEDs = ((r_state == DONE) && r_blink) ? 16'hFFFF : 16'h0000;
`else
   assign bus.o_LEDs = (r_state == DONE) ? 16'hFFFF : 16'h0000;
`endif

endmodule

// File: doc/bcd_upcounter_2d.md
# bcd_upcounter_2d

Two-digit BCD up-counter for the lab timer datapath: the counting-up counterpart of the down-counting digit chain. Counts 00 → LIMIT once per clk_d cycle while running, propagates a carry from the ones digit to the tens digit, and supports start/pause toggling, synchronous clear and a terminal DONE state that drives the LED bank. Sits between the one-pulse/debounce front end and the seven-segment display scanner.

## Interface

- LIMIT_D1, default 3, tens digit of terminal count (BCD 0–9)
- LIMIT_D0, default 0, ones digit of terminal count (BCD 0–9)

- clk_d  in  1  counting clock (divided, one tick per count)
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear, active-high
- start_pause  in  1  single-cycle toggle pulse (already one-pulsed)
- d0  out  4  ones digit, BCD
- d1  out  4  tens digit, BCD
- cy0  out  1  ones→tens carry (combinational)
- done  out  1  high in DONE state
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3
- LEDs  out  16  LED bank

## Operation

- Reset values: state=IDLE, d1=d0=0, done=0, cy0=0, LEDs=16'h0000.
- Input priority per edge: clr > start_pause > count.
- clr (any state): next edge → IDLE, d1=d0=0, LEDs=0, done=0.
- IDLE: hold 00; start_pause → RUN (no increment on that edge). If LIMIT=00, start_pause → DONE directly.
- RUN: each edge increments {d1,d0} in BCD. d0=9 → d0=0, d1=d1+1. cy0=1 exactly when state=RUN, d0=9, no clr/start_pause this cycle; else 0.
- The edge that makes {d1,d0}=={LIMIT_D1,LIMIT_D0} also moves state to DONE; counter never exceeds LIMIT.
- RUN with start_pause → PAUSE, value held, no increment on that edge.
- PAUSE: hold; start_pause → RUN. cy0=0.
- DONE: hold LIMIT; done=1; start_pause ignored; only clr or rst exits.
- LEDs=0 in IDLE/RUN/PAUSE; DONE behaviour per Configuration.
- d1 wrap never occurs: LIMIT ≤ 99 is a parameter constraint; non-BCD LIMIT digits are illegal (elaboration error preferred).

## Timing

- All state/digit updates on posedge clk_d; rst overrides asynchronously.
- Start latency: start_pause sampled at edge N → state=RUN after N; first increment at edge N+1.
- Done latency: done and LEDs update on the same edge the count reaches LIMIT (zero extra cycles).
- cy0 is combinational from state/d0/inputs; valid before the edge that performs the tens increment.
- rst mid-count: immediate return to reset values, no glitch-through of old count at next edge.

## Configuration

- UPCNT_LED_BLINK_EN defined: in DONE, LEDs alternate 16'hFFFF / 16'h0000 every clk_d edge, starting 16'hFFFF on the DONE-entry edge; blink register cleared by rst/clr.
- Undefined: in DONE, LEDs=16'hFFFF steady.

## Test plan

- rst pulse mid-RUN at count 17 → d1=0, d0=0, state=0, LEDs=0 immediately, no count on next edge until start_pause.
- start_pause, run 10 edges → count 00→10; cy0=1 only in cycle with d0=9, d1 steps 0→1 on that edge.
- Default LIMIT=30: start then 30 edges → d1=3, d0=0, done=1, state=3, LEDs=FFFF on that edge; 5 more edges → still 30.
- RUN at 12, start_pause → PAUSE holds 12 for 4 edges; start_pause → RUN, next edge 13.
- DONE, start_pause → ignored; clr → next edge 00, IDLE, LEDs=0; clr and start_pause same cycle in RUN → IDLE.
- UPCNT_LED_BLINK_EN defined, DONE → LEDs FFFF,0000,FFFF on successive edges; LIMIT=00 build: start_pause in IDLE → DONE next edge.
